// File: rtl/adder_pkg.sv
// Shared definitions for the serial flag adder.
// Holds the FSM state encoding and the default operand/chunk widths.
package adder_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefChunk = 4;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
// Ports:
//   i_a, i_b  : CHUNK-bit operand slices
//   i_cin     : carry into the slice
//   o_sum     : CHUNK-bit slice sum
//   o_cout    : carry out of the slice MSB
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  // One extra bit of headroom captures the slice carry.
  logic [CHUNK:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
  assign o_sum  = w_full[CHUNK-1:0];
  assign o_cout = w_full[CHUNK];

endmodule

// File: rtl/serial_flag_adder.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock and
// reports sum plus carry, sign, zero, parity and overflow flags.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : operation request (accepted when idle or on the
//                     completion edge of the running operation)
//   sub, cin        : 0 -> a+b+cin, 1 -> a-b (cin ignored)
//   a, b            : WIDTH-bit operands
//   busy            : operation in progress
//   done            : one-cycle pulse when new results are valid
//   sum, carry      : result and carry out (for sub, 1 = no borrow)
//   sign, zero      : sum MSB, sum == 0
//   parity          : even-parity indicator (~^sum)
//   overflow        : two's-complement overflow
module serial_flag_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CHUNK = DefChunk
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             sign,
  output logic             zero,
  output logic             parity,
  output logic             overflow
);

  // WIDTH must be a multiple of CHUNK.
  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned IdxW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;      // effective b (inverted for sub)
  logic [WIDTH-1:0] r_part;   // partial sums, filled chunk by chunk
  logic             r_c;      // running carry
  logic [IdxW-1:0]  r_idx;

  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_sign;
  logic             r_zero;
  logic             r_parity;
  logic             r_ovf;
  logic             r_done;

  logic [WIDTH-1:0] w_beff;
  logic             w_cin_eff;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK-1:0] w_cs;
  logic             w_cout;
  logic [WIDTH-1:0] w_final;
  logic             w_ovf;

  assign w_beff    = sub ? ~b : b;
  assign w_cin_eff = sub | cin;

  assign w_ca = r_a[r_idx*CHUNK +: CHUNK];
  assign w_cb = r_b[r_idx*CHUNK +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .i_a    (w_ca),
    .i_b    (w_cb),
    .i_cin  (r_c),
    .o_sum  (w_cs),
    .o_cout (w_cout)
  );

  // Full result as it will be on the completion edge: lower chunks already
  // stored, top chunk straight from the adder.
  always_comb begin
    w_final = r_part;
    w_final[WIDTH-1 -: CHUNK] = w_cs;
  end

  assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_final[WIDTH-1] != r_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_a      <= '0;
      r_b      <= '0;
      r_part   <= '0;
      r_c      <= 1'b0;
      r_idx    <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_sign   <= 1'b0;
      r_zero   <= 1'b0;
      r_parity <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a     <= a;
            r_b     <= w_beff;
            r_c     <= w_cin_eff;
            r_idx   <= '0;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_part[r_idx*CHUNK +: CHUNK] <= w_cs;
          r_c   <= w_cout;
          r_idx <= r_idx + IdxW'(1);
          if (r_idx == LastIdx) begin
            r_sum    <= w_final;
            r_carry  <= w_cout;
            r_sign   <= w_final[WIDTH-1];
            r_zero   <= (w_final == '0);
            r_parity <= ~^w_final;
            r_ovf    <= w_ovf;
            r_done   <= 1'b1;
            // The completion edge also samples start so a held request
            // restarts immediately and busy stays high between operations.
            if (start) begin
              r_a   <= a;
              r_b   <= w_beff;
              r_c   <= w_cin_eff;
              r_idx <= '0;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy     = (r_state == StRun);
  assign done     = r_done;
  assign sum      = r_sum;
  assign carry    = r_carry;
  assign sign     = r_sign;
  assign zero     = r_zero;
  assign parity   = r_parity;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_flag_adder.sv
// Self-checking bench for serial_flag_adder (WIDTH=16, CHUNK=4).
module tb_serial_flag_adder;

  localparam int unsigned W   = 16;
  localparam int unsigned C   = 4;
  localparam int unsigned NCH = W / C;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic          cin;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          carry;
  logic          sign;
  logic          zero;
  logic          parity;
  logic          overflow;

  int checks   = 0;
  int failures = 0;
  bit tb_go    = 1'b0;

  serial_flag_adder #(
    .WIDTH (W),
    .CHUNK (C)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry    (carry),
    .sign     (sign),
    .zero     (zero),
    .parity   (parity),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Result vector layout: {sum, carry, sign, zero, parity, overflow}
  function automatic logic [20:0] calc(input logic [15:0] x, input logic [15:0] y,
                                       input logic s, input logic ci);
    logic [15:0] r;
    logic        co;
    logic        ov;
    int          sr;
    int          ur;
    if (s) begin
      sr = int'($signed(x)) - int'($signed(y));
      ur = int'(x) - int'(y);
      co = (x >= y);
    end else begin
      sr = int'($signed(x)) + int'($signed(y)) + int'(ci);
      ur = int'(x) + int'(y) + int'(ci);
      co = (ur > 65535);
    end
    r  = 16'(ur);
    ov = (sr > 32767) || (sr < -32768);
    return {r, co, r[15], (r == 16'h0000), (($countones(r) % 2) == 0), ov};
  endfunction

  function automatic logic [20:0] dut_res();
    return {sum, carry, sign, zero, parity, overflow};
  endfunction

  // Transaction-level model: at most one operation in flight, each due NCH
  // edges after acceptance; a new request is taken whenever nothing is
  // pending after retiring the one that completes on this edge.
  typedef struct {
    logic [20:0] res;
    int unsigned due;
  } op_t;

  op_t         pend[$];
  int unsigned cyc = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [20:0] m_res  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_res  = '0;
    end else begin
      op_t op;
      cyc++;
      m_done = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_res  = pend[0].res;
        m_done = 1'b1;
        void'(pend.pop_front());
      end
      if (start && pend.size() == 0) begin
        op.res = calc(a, b, sub, cin);
        op.due = cyc + NCH;
        pend.push_back(op);
      end
      m_busy = (pend.size() > 0);
    end
  end

  always @(negedge clk) begin
    if (tb_go) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("result", 32'(dut_res()), 32'(m_res));
    end
  end

  // Issue one operation from a negedge and wait for done; check latency and
  // a hand-computed literal result. Operands are scrambled during RUN.
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                       input logic ci, input string nm, input logic [20:0] lit);
    int n;
    start = 1'b1;
    a = x;
    b = y;
    sub = s;
    cin = ci;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    sub = 1'($urandom);
    cin = 1'($urandom);
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(NCH));
    chk(nm, 32'(dut_res()), 32'(lit));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int ngap;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    chk("reset_outputs", 32'({busy, done, sum, carry, sign, zero, parity, overflow}), 32'd0);
    tb_go = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'hBFFF, 16'h8000, 1'b0, 1'b0, "add_bfff_8000", {16'h3FFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    repeat (2) @(negedge clk);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_ffff_0001", {16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    do_op(16'h7FFF, 16'h0000, 1'b0, 1'b1, "add_7fff_cin", {16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_0005_0007", {16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, "sub_8000_0001", {16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    repeat (3) @(negedge clk);

    // Held start with operands changing every cycle.
    start = 1'b1;
    a = 16'h1234;
    b = 16'hF00D;
    sub = 1'b0;
    cin = 1'b1;
    ndone = 0;
    ngap  = 0;
    for (int k = 0; k <= 4 * int'(NCH); k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (!busy) ngap++;
      a = 16'($urandom);
      b = 16'($urandom);
      sub = 1'($urandom);
      cin = 1'($urandom);
    end
    start = 1'b0;
    chk("b2b_done_count", 32'(ndone), 32'd4);
    chk("b2b_busy_gaps", 32'(ngap), 32'd0);
    repeat (NCH + 2) @(negedge clk);

    // Reset in the second RUN cycle.
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, "sub_pre_reset", {16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    start = 1'b1;
    a = 16'h0F0F;
    b = 16'h0101;
    sub = 1'b0;
    cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset", 32'({busy, done, sum, carry, sign, zero, parity, overflow}), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, "post_reset", {16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
